// File: rtl/request_panel_if.sv
// Button/arrival inputs and command/status outputs of the request panel.
// The panel side uses the master modport; the controller/button-matrix side uses slave.
interface request_panel_if #(
    parameter int FLOORS = 8
);
    logic [FLOORS-1:0] callBtn;
    logic [FLOORS-1:0] cancelBtn;
    logic              ctrlBusy;
    logic              arriveValid;
    logic [3:0]        arriveFloor;
    logic [1:0]        mode;
    logic [3:0]        request;
    logic [FLOORS-1:0] pendingLeds;
    logic [3:0]        poolCount;
    logic              poolFull;
    logic              dropPulse;

    modport master (
        input  callBtn, cancelBtn, ctrlBusy, arriveValid, arriveFloor,
        output mode, request, pendingLeds, poolCount, poolFull, dropPulse
    );

    modport slave (
        output callBtn, cancelBtn, ctrlBusy, arriveValid, arriveFloor,
        input  mode, request, pendingLeds, poolCount, poolFull, dropPulse
    );
endinterface

// File: rtl/request_panel.sv
// Call/cancel entry panel issuing one-cycle add/delete commands to the dual-car controller.
// Defining REQUEST_PANEL_DEBOUNCE_EN inserts a 3-sample stability filter on every button.
module request_panel #(
    parameter int FLOORS     = 8,
    parameter int POOL_DEPTH = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    request_panel_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_DEL = 2'b10;
    localparam logic [1:0] MODE_RUN = 2'b11;
    localparam logic [3:0] POOL_MAX = 4'(POOL_DEPTH);

    state_t            state, state_next;
    logic [FLOORS-1:0] call_lvl, cancel_lvl, call_q, cancel_q;
    logic [FLOORS-1:0] call_edge, cancel_edge;
    logic [FLOORS-1:0] add_pend, del_pend, reg_set;
    logic [FLOORS-1:0] add_n, del_n, reg_n;
    logic [3:0]        pool_cnt, cnt_n;
    logic [1:0]        mode_r, mode_n;
    logic [3:0]        request_r, request_n;
    logic [FLOORS-1:0] leds_r;
    logic              full_r, drop_r, drop_n;
    logic              arr_hit;
    logic [3:0]        arr_idx;
    logic [FLOORS-1:0] arr_mask, del_avail;
    logic              sel_del, sel_add, go, go_add;
    logic [3:0]        sel_idx;

`ifdef REQUEST_PANEL_DEBOUNCE_EN
    logic [1:0]        call_cnt   [FLOORS];
    logic [1:0]        cancel_cnt [FLOORS];
    logic [FLOORS-1:0] call_filt, cancel_filt;

    // The filtered level follows the raw level only after three consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            call_filt   <= '0;
            cancel_filt <= '0;
            for (int f = 0; f < FLOORS; f++) begin
                call_cnt[f]   <= 2'd0;
                cancel_cnt[f] <= 2'd0;
            end
        end else begin
            for (int f = 0; f < FLOORS; f++) begin
                if (bus.callBtn[f] == call_filt[f]) begin
                    call_cnt[f] <= 2'd0;
                end else if (call_cnt[f] == 2'd2) begin
                    call_filt[f] <= bus.callBtn[f];
                    call_cnt[f]  <= 2'd0;
                end else begin
                    call_cnt[f] <= call_cnt[f] + 2'd1;
                end
                if (bus.cancelBtn[f] == cancel_filt[f]) begin
                    cancel_cnt[f] <= 2'd0;
                end else if (cancel_cnt[f] == 2'd2) begin
                    cancel_filt[f] <= bus.cancelBtn[f];
                    cancel_cnt[f]  <= 2'd0;
                end else begin
                    cancel_cnt[f] <= cancel_cnt[f] + 2'd1;
                end
            end
        end
    end

    assign call_lvl   = call_filt;
    assign cancel_lvl = cancel_filt;
`else
    assign call_lvl   = bus.callBtn;
    assign cancel_lvl = bus.cancelBtn;
`endif

    assign call_edge   = call_lvl & ~call_q;
    assign cancel_edge = cancel_lvl & ~cancel_q;

    assign arr_hit = bus.arriveValid && (bus.arriveFloor != 4'd0) &&
                     (int'(bus.arriveFloor) <= FLOORS);
    assign arr_idx = bus.arriveFloor - 4'd1;

    always_comb begin
        arr_mask = '0;
        for (int f = 0; f < FLOORS; f++) begin
            arr_mask[f] = arr_hit && (arr_idx == 4'(f));
        end
    end

    // A delete whose floor is being served this cycle is moot, so it is not offered for issue.
    assign del_avail = del_pend & ~arr_mask;

    always_comb begin
        sel_del = 1'b0;
        sel_add = 1'b0;
        sel_idx = 4'd0;
        for (int f = FLOORS - 1; f >= 0; f--) begin
            if (add_pend[f]) begin
                sel_add = 1'b1;
                sel_idx = 4'(f);
            end
        end
        for (int f = FLOORS - 1; f >= 0; f--) begin
            if (del_avail[f]) begin
                sel_del = 1'b1;
                sel_idx = 4'(f);
            end
        end
        if (sel_del) begin
            sel_add = 1'b0;
        end
    end

    assign go     = (state == IDLE) && !bus.ctrlBusy && (sel_del || sel_add);
    assign go_add = go && sel_add;

    // Applied in order: arrivals, button edges, then the command, so the command has the last word.
    always_comb begin
        state_next = state;
        add_n      = add_pend;
        del_n      = del_pend;
        reg_n      = reg_set;
        cnt_n      = pool_cnt;
        mode_n     = MODE_RUN;
        request_n  = 4'd0;
        drop_n     = 1'b0;

        for (int f = 0; f < FLOORS; f++) begin
            if (arr_mask[f]) begin
                if (reg_set[f]) begin
                    cnt_n = cnt_n - 4'd1;
                end
                reg_n[f] = 1'b0;
                del_n[f] = 1'b0;
            end
        end

        for (int f = 0; f < FLOORS; f++) begin
            if (cancel_edge[f]) begin
                if (add_pend[f] && !(go_add && sel_idx == 4'(f))) begin
                    add_n[f] = 1'b0;
                end else if (reg_n[f] || add_pend[f]) begin
                    del_n[f] = 1'b1;
                end
            end else if (call_edge[f] && !add_pend[f] && !reg_set[f] && !del_pend[f]) begin
                add_n[f] = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (go) begin
                    state_next = ISSUE;
                    for (int f = 0; f < FLOORS; f++) begin
                        if (sel_idx == 4'(f)) begin
                            if (sel_del) begin
                                if (reg_n[f]) begin
                                    cnt_n = cnt_n - 4'd1;
                                end
                                del_n[f]  = 1'b0;
                                reg_n[f]  = 1'b0;
                                mode_n    = MODE_DEL;
                                request_n = 4'(f + 1);
                            end else if (cnt_n < POOL_MAX) begin
                                add_n[f]  = 1'b0;
                                reg_n[f]  = 1'b1;
                                cnt_n     = cnt_n + 4'd1;
                                mode_n    = MODE_ADD;
                                request_n = 4'(f + 1);
                            end else begin
                                add_n[f] = 1'b0;
                                drop_n   = 1'b1;
                            end
                        end
                    end
                end
            end
            ISSUE:   state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            call_q    <= '0;
            cancel_q  <= '0;
            add_pend  <= '0;
            del_pend  <= '0;
            reg_set   <= '0;
            pool_cnt  <= 4'd0;
            mode_r    <= MODE_RUN;
            request_r <= 4'd0;
            leds_r    <= '0;
            full_r    <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            state     <= state_next;
            call_q    <= call_lvl;
            cancel_q  <= cancel_lvl;
            add_pend  <= add_n;
            del_pend  <= del_n;
            reg_set   <= reg_n;
            pool_cnt  <= cnt_n;
            mode_r    <= mode_n;
            request_r <= request_n;
            leds_r    <= add_n | reg_n;
            full_r    <= (cnt_n == POOL_MAX);
            drop_r    <= drop_n;
        end
    end

    assign bus.mode        = mode_r;
    assign bus.request     = request_r;
    assign bus.pendingLeds = leds_r;
    assign bus.poolCount   = pool_cnt;
    assign bus.poolFull    = full_r;
    assign bus.dropPulse   = drop_r;
endmodule

// File: tb/tb_request_panel.sv
// Directed bench for request_panel: adds, deletes, busy hold-off, pool overflow, arrivals, reset.
module tb_request_panel;
    localparam int FLOORS     = 10;
    localparam int POOL_DEPTH = 8;

    logic CLK;
    logic RST_N;
    int   total;
    int   bad;

    request_panel_if #(.FLOORS(FLOORS)) bus ();

    request_panel #(
        .FLOORS     (FLOORS),
        .POOL_DEPTH (POOL_DEPTH)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Holds the given button pattern for exactly one sampled cycle.
    task automatic applyStimulus(input logic [FLOORS-1:0] calls, input logic [FLOORS-1:0] cancels);
        bus.callBtn   = calls;
        bus.cancelBtn = cancels;
        tick();
        bus.callBtn   = '0;
        bus.cancelBtn = '0;
    endtask

    task automatic arrive(input logic [3:0] code);
        bus.arriveValid = 1'b1;
        bus.arriveFloor = code;
        tick();
        bus.arriveValid = 1'b0;
        bus.arriveFloor = 4'd0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total           = 0;
        bad             = 0;
        RST_N           = 1'b0;
        bus.callBtn     = '0;
        bus.cancelBtn   = '0;
        bus.ctrlBusy    = 1'b0;
        bus.arriveValid = 1'b0;
        bus.arriveFloor = 4'd0;
        tick();
        tick();
        RST_N = 1'b1;

        checkOutput("reset_mode", 32'(bus.mode), 32'h3);
        checkOutput("reset_request", 32'(bus.request), 32'h0);
        checkOutput("reset_leds", 32'(bus.pendingLeds), 32'h0);
        checkOutput("reset_count", 32'(bus.poolCount), 32'h0);
        checkOutput("reset_full", 32'(bus.poolFull), 32'h0);
        checkOutput("reset_drop", 32'(bus.dropPulse), 32'h0);

        // Single call on floor 2
        applyStimulus(10'h004, 10'h000);
        checkOutput("call2_wait_mode", 32'(bus.mode), 32'h3);
        tick();
        checkOutput("call2_mode", 32'(bus.mode), 32'h0);
        checkOutput("call2_request", 32'(bus.request), 32'h3);
        checkOutput("call2_leds", 32'(bus.pendingLeds), 32'h004);
        checkOutput("call2_count", 32'(bus.poolCount), 32'h1);
        tick();
        checkOutput("call2_gap_mode", 32'(bus.mode), 32'h3);
        checkOutput("call2_gap_request", 32'(bus.request), 32'h0);
        tick();

        // Floors 0 and 5 together: lowest first, three cycles apart
        applyStimulus(10'h021, 10'h000);
        tick();
        checkOutput("dual_first_mode", 32'(bus.mode), 32'h0);
        checkOutput("dual_first_request", 32'(bus.request), 32'h1);
        tick();
        checkOutput("dual_gap_mode", 32'(bus.mode), 32'h3);
        tick();
        checkOutput("dual_idle_mode", 32'(bus.mode), 32'h3);
        tick();
        checkOutput("dual_second_mode", 32'(bus.mode), 32'h0);
        checkOutput("dual_second_request", 32'(bus.request), 32'h6);
        checkOutput("dual_leds", 32'(bus.pendingLeds), 32'h025);
        checkOutput("dual_count", 32'(bus.poolCount), 32'h3);
        tick();
        tick();

        // Register floor 4, then cancel it
        applyStimulus(10'h010, 10'h000);
        tick();
        checkOutput("reg4_request", 32'(bus.request), 32'h5);
        checkOutput("reg4_count", 32'(bus.poolCount), 32'h4);
        tick();
        tick();
        applyStimulus(10'h000, 10'h010);
        tick();
        checkOutput("del4_mode", 32'(bus.mode), 32'h2);
        checkOutput("del4_request", 32'(bus.request), 32'h5);
        checkOutput("del4_count", 32'(bus.poolCount), 32'h3);
        checkOutput("del4_leds", 32'(bus.pendingLeds), 32'h025);
        tick();
        tick();

        // Busy controller holds off the add for floor 1
        bus.ctrlBusy = 1'b1;
        applyStimulus(10'h002, 10'h000);
        checkOutput("busy_leds", 32'(bus.pendingLeds), 32'h027);
        checkOutput("busy_mode_a", 32'(bus.mode), 32'h3);
        tick();
        tick();
        checkOutput("busy_mode_b", 32'(bus.mode), 32'h3);
        bus.ctrlBusy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.mode == 2'b00) break;
        end
        checkOutput("unbusy_mode", 32'(bus.mode), 32'h0);
        checkOutput("unbusy_request", 32'(bus.request), 32'h2);
        checkOutput("unbusy_count", 32'(bus.poolCount), 32'h4);
        tick();
        tick();

        // Fill the pool with floors 3,4,6,7
        applyStimulus(10'h0D8, 10'h000);
        tick();
        checkOutput("fill_first_request", 32'(bus.request), 32'h4);
        for (int i = 0; i < 11; i++) tick();
        checkOutput("fill_count", 32'(bus.poolCount), 32'h8);
        checkOutput("fill_full", 32'(bus.poolFull), 32'h1);
        checkOutput("fill_leds", 32'(bus.pendingLeds), 32'h0FF);

        // Ninth floor is refused
        applyStimulus(10'h100, 10'h000);
        tick();
        checkOutput("drop_pulse", 32'(bus.dropPulse), 32'h1);
        checkOutput("drop_mode", 32'(bus.mode), 32'h3);
        checkOutput("drop_request", 32'(bus.request), 32'h0);
        checkOutput("drop_leds", 32'(bus.pendingLeds), 32'h0FF);
        checkOutput("drop_count", 32'(bus.poolCount), 32'h8);
        tick();
        checkOutput("drop_pulse_end", 32'(bus.dropPulse), 32'h0);
        tick();

        // Arrivals: valid code 1, then out-of-range codes 11 and 0, then code 4
        arrive(4'd1);
        checkOutput("arr1_count", 32'(bus.poolCount), 32'h7);
        checkOutput("arr1_full", 32'(bus.poolFull), 32'h0);
        checkOutput("arr1_leds", 32'(bus.pendingLeds), 32'h0FE);
        arrive(4'd11);
        checkOutput("arr11_count", 32'(bus.poolCount), 32'h7);
        arrive(4'd0);
        checkOutput("arr0_count", 32'(bus.poolCount), 32'h7);
        arrive(4'd4);
        checkOutput("arr4_count", 32'(bus.poolCount), 32'h6);
        checkOutput("arr4_leds", 32'(bus.pendingLeds), 32'h0F6);

        // Call and cancel on floor 3 together: nothing issued
        applyStimulus(10'h008, 10'h008);
        checkOutput("callcancel_leds", 32'(bus.pendingLeds), 32'h0F6);
        tick();
        checkOutput("callcancel_mode_a", 32'(bus.mode), 32'h3);
        tick();
        checkOutput("callcancel_mode_b", 32'(bus.mode), 32'h3);
        checkOutput("callcancel_count", 32'(bus.poolCount), 32'h6);

        // Reset while an add for floor 9 is on the bus
        applyStimulus(10'h200, 10'h000);
        tick();
        checkOutput("preRst_mode", 32'(bus.mode), 32'h0);
        checkOutput("preRst_request", 32'(bus.request), 32'hA);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        checkOutput("rst_mode", 32'(bus.mode), 32'h3);
        checkOutput("rst_request", 32'(bus.request), 32'h0);
        checkOutput("rst_count", 32'(bus.poolCount), 32'h0);
        checkOutput("rst_leds", 32'(bus.pendingLeds), 32'h0);
        tick();
        checkOutput("post_rst_mode", 32'(bus.mode), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
